conv_frame_encoder: RTL
=======================

Name: conv_frame_encoder

Overview:
- Frame-level convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder inside endec.
- Accepts one DATA_FRAME_LENGTH-bit data frame over a valid/ready handshake and encodes it one bit per cycle with programmable code rate, constraint length and generator polynomials.
- Returns a packed encoded frame in the layout the decoder's frame input consumes.
- Used as the stimulus source for endec regression and as the TX path in loopback builds.

Parameters:
- DATA_FRAME_LENGTH, 8, data bits per frame.
- MAX_CODE_RATE, 3, maximum output bits per input bit (rate 1/3).
- MAX_CONSTRAINT_LENGTH, 9, maximum K; width of each generator polynomial.
- ENC_FRAME_WIDTH, MAX_CODE_RATE*DATA_FRAME_LENGTH (24), width of the encoded frame.

Ports:
- sys_clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; 0 freezes all state.
- i_code_rate  in  1  1 = rate 1/2 (polys 0,1); 0 = rate 1/3 (polys 0,1,2).
- i_constr_len  in  2  01 = K3, 10 = K5, 11 = K7, 00 = K9.
- i_gen_poly  in  [MAX_CONSTRAINT_LENGTH-1:0] x MAX_CODE_RATE  generator polynomials.
- i_data_frame  in  DATA_FRAME_LENGTH  data bits; MSB is encoded first.
- i_valid  in  1  data frame valid.
- o_ready  out  1  block can accept a frame.
- o_encoded_frame  out  ENC_FRAME_WIDTH  packed encoded symbols.
- o_valid  out  1  encoded frame valid.
- i_ready  in  1  downstream accepts the encoded frame.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, o_ready=1, o_valid=0, o_encoded_frame=0, shift register=0, bit counter=0.
- Enable: with en=0, no register changes and no handshake completes (o_ready and o_valid hold their values).
- FSM states:
  - IDLE: o_ready=1. On i_valid&o_ready&en, latch the frame, code rate, K and polys; clear the shift register and o_encoded_frame; go to ENCODE.
  - ENCODE: o_ready=0. Each enabled cycle, process bit u = frame[DATA_FRAME_LENGTH-1-cnt]. After the bit with cnt = DATA_FRAME_LENGTH-1, go to DONE.
  - DONE: o_valid=1 and o_encoded_frame is stable. On i_ready&en, clear o_valid and go to IDLE. A new frame is accepted in the cycle after DONE exits, not in the same cycle.
- Latency: o_valid rises exactly DATA_FRAME_LENGTH enabled edges after the accept edge.
- Tap vector: element 0 = u, element j = input j bits earlier; elements j >= K are forced to 0.
- Symbol: g_i = XOR over j of (poly_i[j] & tap[j]). Polynomial bits at or above K are ignored (masked).
- Per-frame state: the shift register starts at 0 for every frame. There are no tail bits; the encoder state carries nothing between frames.
- Packing, rate 1/2: symbol n (n=0 is the first bit) is written as {g0,g1} at bits [15-2n : 14-2n]; bits [23:16] are 0.
- Packing, rate 1/3: symbol n is written as {g0,g1,g2} at bits [23-3n : 21-3n].
- Configuration changes while the FSM is not IDLE have no effect on the frame in flight.
- i_valid while busy is ignored; the frame is not queued.
- Reset mid-ENCODE or mid-DONE discards the frame and returns to IDLE immediately.

Decomposition:
- Shared package param_def.sv holds:
  - `DATA_FRAME_LENGTH, `MAX_CODE_RATE, `MAX_CONSTRAINT_LENGTH.
  - Code-rate encodings RATE_1_2=1, RATE_1_3=0.
  - The constraint-length decode function (2-bit code -> K and tap mask).
  - FSM state enum {IDLE, ENCODE, DONE}.
- One sub-module, conv_symbol_gen: combinational; takes the tap vector, K mask and polys and returns the MAX_CODE_RATE-bit symbol.

Test Plan:
- Impulse: K=3 (01), rate 1/2, polys 111/101, data 8'b10000000 -> o_valid 8 cycles after accept, o_encoded_frame=24'h00EC00.
- Pattern: same configuration, data 8'b11110000 -> 24'h00DA70. The bench then loops this frame into endec decode mode and checks it returns 8'b11110000.
- Rate 1/3: K=3, polys 111/101/011, data 8'b10000000 -> 24'hF70000.
- Masking: K=3, rate 1/2, both polys 9'h1FF, data 8'b10000000 -> 24'h00FC00 (identical to polys 111/111).
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid and the frame stay stable, o_ready stays 0, and an i_valid pulse is ignored. After i_ready=1, o_ready=1 on the next cycle.
- Reset and enable: assert rst low at the 4th ENCODE cycle -> o_valid=0, o_ready=1 immediately. Deasserting en for 3 cycles mid-frame delays o_valid by exactly 3 cycles with the same result.

Source files
------------

// File: rtl/conv_frame_encoder_pkg.sv
// Shared definitions for the frame-level convolutional encoder.
// Includes frame geometry, code-rate encodings, the constraint-length decode and FSM states.
package conv_frame_encoder_pkg;

    localparam int DATA_FRAME_LENGTH     = 8;
    localparam int MAX_CODE_RATE         = 3;
    localparam int MAX_CONSTRAINT_LENGTH = 9;
    localparam int ENC_FRAME_WIDTH       = MAX_CODE_RATE * DATA_FRAME_LENGTH;
    localparam int CNT_W                 = $clog2(DATA_FRAME_LENGTH);

    localparam logic RATE_1_2 = 1'b1;
    localparam logic RATE_1_3 = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        DONE
    } enc_state_e;

    // 01 -> K3, 10 -> K5, 11 -> K7, 00 -> K9
    function automatic int unsigned constr_k(input logic [1:0] code);
        int unsigned k;
        case (code)
            2'b01:   k = 3;
            2'b10:   k = 5;
            2'b11:   k = 7;
            default: k = 9;
        endcase
        return k;
    endfunction

    function automatic logic [MAX_CONSTRAINT_LENGTH-1:0] constr_mask(input logic [1:0] code);
        return MAX_CONSTRAINT_LENGTH'((32'd1 << constr_k(code)) - 32'd1);
    endfunction

endpackage

// File: rtl/conv_frame_encoder_symbol_gen.sv
// Combinational symbol generator: one output bit per generator polynomial.
// Taps and polynomial bits at or above K are removed by the K mask.
module conv_symbol_gen
    import conv_frame_encoder_pkg::*;
(
    input  logic [MAX_CONSTRAINT_LENGTH-1:0]                    i_tap,
    input  logic [MAX_CONSTRAINT_LENGTH-1:0]                    i_k_mask,
    input  logic [MAX_CODE_RATE-1:0][MAX_CONSTRAINT_LENGTH-1:0] i_gen_poly,
    output logic [MAX_CODE_RATE-1:0]                            o_symbol
);

    always_comb begin
        o_symbol = '0;
        for (int unsigned i = 0; i < MAX_CODE_RATE; i++) begin
            o_symbol[i] = ^(i_gen_poly[i] & i_tap & i_k_mask);
        end
    end

endmodule

// File: rtl/conv_frame_encoder.sv
// Frame-level convolutional encoder: accepts one data frame, encodes it MSB first at
// one bit per enabled cycle, and presents the packed encoded frame until taken.
module conv_frame_encoder
    import conv_frame_encoder_pkg::*;
(
    input  logic                                                sys_clk,
    input  logic                                                rst,
    input  logic                                                en,
    input  logic                                                i_code_rate,
    input  logic [1:0]                                          i_constr_len,
    input  logic [MAX_CODE_RATE-1:0][MAX_CONSTRAINT_LENGTH-1:0] i_gen_poly,
    input  logic [DATA_FRAME_LENGTH-1:0]                        i_data_frame,
    input  logic                                                i_valid,
    output logic                                                o_ready,
    output logic [ENC_FRAME_WIDTH-1:0]                          o_encoded_frame,
    output logic                                                o_valid,
    input  logic                                                i_ready
);

    enc_state_e                                          state_q, state_d;
    logic [DATA_FRAME_LENGTH-1:0]                        frame_q;
    logic                                                rate_q;
    logic [MAX_CONSTRAINT_LENGTH-1:0]                    mask_q;
    logic [MAX_CODE_RATE-1:0][MAX_CONSTRAINT_LENGTH-1:0] poly_q;
    logic [MAX_CONSTRAINT_LENGTH-2:0]                    sr_q;
    logic [CNT_W-1:0]                                    cnt_q;
    logic [ENC_FRAME_WIDTH-1:0]                          enc_q;
    logic [ENC_FRAME_WIDTH-1:0]                          placed;
    logic [MAX_CONSTRAINT_LENGTH-1:0]                    tap;
    logic [MAX_CODE_RATE-1:0]                            sym;
    logic                                                accept;
    logic                                                step;
    logic                                                last_bit;
    int unsigned                                         rem;

    // The frame register shifts left, so its MSB is always the current bit u.
    assign tap      = {sr_q, frame_q[DATA_FRAME_LENGTH-1]};
    assign accept   = en & i_valid & (state_q == IDLE);
    assign step     = en & (state_q == ENCODE);
    assign last_bit = (cnt_q == CNT_W'(DATA_FRAME_LENGTH - 1));

    conv_symbol_gen u_symbol_gen (
        .i_tap      (tap),
        .i_k_mask   (mask_q),
        .i_gen_poly (poly_q),
        .o_symbol   (sym)
    );

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (en && i_valid) state_d = ENCODE;
            end
            ENCODE: begin
                if (en && last_bit) state_d = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (en && i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else if (en) state_q <= state_d;
    end

    // Symbol n lands at its final bit position; the frame is cleared on accept, so OR-in is enough.
    always_comb begin
        rem    = DATA_FRAME_LENGTH - 1 - 32'(cnt_q);
        placed = '0;
        if (rate_q == RATE_1_2) placed = ENC_FRAME_WIDTH'({sym[0], sym[1]}) << (2 * rem);
        else placed = ENC_FRAME_WIDTH'({sym[0], sym[1], sym[2]}) << (3 * rem);
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            frame_q <= '0;
            rate_q  <= RATE_1_3;
            mask_q  <= '0;
            poly_q  <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            enc_q   <= '0;
        end else if (accept) begin
            frame_q <= i_data_frame;
            rate_q  <= i_code_rate;
            mask_q  <= constr_mask(i_constr_len);
            poly_q  <= i_gen_poly;
            sr_q    <= '0;
            cnt_q   <= '0;
            enc_q   <= '0;
        end else if (step) begin
            frame_q <= frame_q << 1;
            sr_q    <= {sr_q[MAX_CONSTRAINT_LENGTH-3:0], frame_q[DATA_FRAME_LENGTH-1]};
            cnt_q   <= cnt_q + 1'b1;
            enc_q   <= enc_q | placed;
        end
    end

    assign o_encoded_frame = enc_q;

endmodule
